// File: rtl/vga_timing_gen.sv
// Parametrised VGA-style raster timing generator with frame-aligned start/stop and a
// configurable output pipeline so sync/coordinates line up with downstream read latency.
module vga_timing_gen #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = 12,
  parameter int unsigned LAT      = 1
) (
  input  logic          pix_clk,
  input  logic          pix_rst,
  input  logic          en,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          hsync,
  output logic          vsync,
  output logic          pix_valid,
  output logic          line_start,
  output logic          frame_start,
  output logic          busy
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned PW      = 2 * CW + 5;

  if (LAT < 1 || LAT > 4) begin : g_bad_lat
    $error("vga_timing_gen: LAT must be in the range 1..4");
  end
  if (CW < 1 || CW > 30 || (1 << CW) <= H_TOTAL || (1 << CW) <= V_TOTAL) begin : g_bad_cw
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end

  localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC);
  localparam logic [CW-1:0] H_ACT_BEG  = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC);
  localparam logic [CW-1:0] V_ACT_BEG  = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

  // Pipeline word: {pix_x, pix_y, hsync, vsync, pix_valid, line_start, frame_start}
  localparam logic [PW-1:0] PIPE_RST = {{(2 * CW){1'b0}}, ~H_POL, ~V_POL, 3'b000};

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
  logic [CW-1:0] cnt_h_adv, cnt_v_adv;
  logic          h_last, v_last;

  logic          in_frame, h_vis, v_vis, vis;
  logic          hs, vs, ls, fs;
  logic [CW-1:0] x, y;
  logic [PW-1:0] pipe_d [LAT];
  logic [PW-1:0] pipe_q [LAT];

  always_comb begin
    h_last    = (cnt_h_q == H_LAST);
    v_last    = (cnt_v_q == V_LAST);
    cnt_h_adv = h_last ? '0 : cnt_h_q + CW'(1);
    cnt_v_adv = cnt_v_q;
    if (h_last) begin
      cnt_v_adv = v_last ? '0 : cnt_v_q + CW'(1);
    end

    state_d = state_q;
    cnt_h_d = cnt_h_adv;
    cnt_v_d = cnt_v_adv;
    case (state_q)
      StIdle: begin
        cnt_h_d = '0;
        cnt_v_d = '0;
        if (en) state_d = StRun;
      end
      StRun: begin
        if (!en) state_d = StStop;
      end
      StStop: begin
        // Only leave STOP on the last pixel so output always ends on a whole frame.
        if (h_last && v_last) state_d = en ? StRun : StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_h_d = '0;
        cnt_v_d = '0;
      end
    endcase
  end

  always_comb begin
    in_frame = (state_q != StIdle);
    h_vis    = (cnt_h_q >= H_ACT_BEG) && (cnt_h_q < H_ACT_END);
    v_vis    = (cnt_v_q >= V_ACT_BEG) && (cnt_v_q < V_ACT_END);
    vis      = in_frame && h_vis && v_vis;
    x        = vis ? cnt_h_q - H_ACT_BEG : '0;
    y        = vis ? cnt_v_q - V_ACT_BEG : '0;
    hs       = (in_frame && (cnt_h_q < H_SYNC_END)) ? H_POL : ~H_POL;
    vs       = (in_frame && (cnt_v_q < V_SYNC_END)) ? V_POL : ~V_POL;
    ls       = (state_q == StRun) && (cnt_h_q == '0);
    fs       = ls && (cnt_v_q == '0);

    pipe_d[0] = {x, y, hs, vs, vis, ls, fs};
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge pix_clk or negedge pix_rst) begin
    if (!pix_rst) begin
      state_q <= StIdle;
      cnt_h_q <= '0;
      cnt_v_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= PIPE_RST;
      end
    end else begin
      state_q <= state_d;
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign {pix_x, pix_y, hsync, vsync, pix_valid, line_start, frame_start} = pipe_q[LAT-1];
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench: a raster model feeds expected words to queues that a monitor drains
// each cycle; a full-size instance gets hand-computed checks on default VGA timing.
module tb_vga_timing_gen;

  localparam int HS = 3, HB = 2, HA = 4, HF = 1;
  localparam int VS = 2, VB = 1, VA = 3, VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;

  typedef logic [12:0] vec_t;  // {x[3:0], y[3:0], hsync, vsync, valid, line_start, frame_start}
  localparam vec_t R1 = 13'b0000_0000_11_000;
  localparam vec_t R3 = 13'b0000_0000_00_000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, rst_b, en_b;
  logic [3:0]  x1, y1, x3, y3;
  logic        hs1, vs1, pv1, ls1, fs1, busy1;
  logic        hs3, vs3, pv3, ls3, fs3, busy3;
  logic [11:0] xd, yd;
  logic        hsd, vsd, pvd, lsd, fsd, busyd;
  vec_t        v1, v3;

  assign v1 = {x1, y1, hs1, vs1, pv1, ls1, fs1};
  assign v3 = {x3, y3, hs3, vs3, pv3, ls3, fs3};

  int n_tot = 0;
  int n_bad = 0;
  int m_st = 0, m_h = 0, m_v = 0;  // model state: 0 idle, 1 run, 2 stop
  vec_t q1[$];
  vec_t q3[$];

  vga_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .H_POL(1'b0), .V_POL(1'b0), .CW(4), .LAT(1)
  ) u_dut1 (
    .pix_clk(clk), .pix_rst(rst), .en(en), .pix_x(x1), .pix_y(y1), .hsync(hs1), .vsync(vs1),
    .pix_valid(pv1), .line_start(ls1), .frame_start(fs1), .busy(busy1)
  );

  vga_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .H_POL(1'b1), .V_POL(1'b1), .CW(4), .LAT(3)
  ) u_dut3 (
    .pix_clk(clk), .pix_rst(rst), .en(en), .pix_x(x3), .pix_y(y3), .hsync(hs3), .vsync(vs3),
    .pix_valid(pv3), .line_start(ls3), .frame_start(fs3), .busy(busy3)
  );

  vga_timing_gen u_dutd (
    .pix_clk(clk), .pix_rst(rst_b), .en(en_b), .pix_x(xd), .pix_y(yd), .hsync(hsd), .vsync(vsd),
    .pix_valid(pvd), .line_start(lsd), .frame_start(fsd), .busy(busyd)
  );

  function automatic vec_t model_out(input int st, input int h, input int v, input bit pol);
    logic [3:0] x, y;
    logic val, hs, vs, ls, fs;
    val = (st != 0) && (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) &&
          (v < VS + VB + VA);
    x   = val ? 4'(h - (HS + HB)) : 4'd0;
    y   = val ? 4'(v - (VS + VB)) : 4'd0;
    hs  = ((st != 0) && (h < HS)) ? pol : ~pol;
    vs  = ((st != 0) && (v < VS)) ? pol : ~pol;
    ls  = (st == 1) && (h == 0);
    fs  = ls && (v == 0);
    return {x, y, hs, vs, val, ls, fs};
  endfunction

  task automatic check(input string name, input vec_t got, input vec_t exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tot++;
    n_bad++;
    $display("FAIL %s t=%0t got=timeout exp=event", name, $time);
  endtask

  task automatic wait_hv(input int v, input int h);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (m_v == v && m_h == h) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) fail("wait_hv");
  endtask

  // Reference raster model: pushes the word each DUT captures on this edge, then steps.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_st = 0;
        m_h  = 0;
        m_v  = 0;
        q1.delete();
        q3.delete();
        q3.push_back(R3);
        q3.push_back(R3);
      end else begin
        bit last;
        q1.push_back(model_out(m_st, m_h, m_v, 1'b0));
        q3.push_back(model_out(m_st, m_h, m_v, 1'b1));
        last = (m_h == HT - 1) && (m_v == VT - 1);
        if (m_st != 0) begin
          if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
          end else begin
            m_h++;
          end
        end
        case (m_st)
          0: if (en) m_st = 1;
          1: if (!en) m_st = 2;
          default: if (last) m_st = en ? 1 : 0;
        endcase
      end
    end
  end

  // Monitor: every cycle the DUTs present a word; compare against the queue heads.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_lat1", v1, R1);
        check("rst_lat3", v3, R3);
      end else if (q1.size() == 0 || q3.size() == 0) begin
        fail("queue_underflow");
      end else begin
        check("lat1", v1, q1.pop_front());
        check("lat3", v3, q3.pop_front());
      end
      check("busy1", 13'(busy1), 13'(m_st != 0));
      check("busy3", 13'(busy3), 13'(m_st != 0));
    end
  end

  initial begin
    int gap, nfs, n, n1, n3;
    int first_ls, ls_cnt, hlow, vlow, first_v, fx, fy, nval, lx, ly, lastc, nz;
    rst = 1'b0;
    en = 1'b0;
    rst_b = 1'b0;
    en_b = 1'b0;
    #32 rst = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (150) @(negedge clk);

    // Drop run request mid-frame; frame completes then generator idles.
    wait_hv(4, 0);
    en = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_busy", 13'(busy1), 13'd0);
    check("idle_hsync", 13'(hs1), 13'd1);
    check("idle_hsync_pol", 13'(hs3), 13'd0);

    // Re-request during STOP: next frame must follow without an idle cycle.
    en = 1'b1;
    wait_hv(2, 0);
    en = 1'b0;
    repeat (20) @(negedge clk);
    en = 1'b1;
    gap = 0;
    nfs = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (!busy1) gap++;
      if (fs1) nfs++;
    end
    check_int("stop_rerun_gap", gap, 0);
    check_int("stop_rerun_fs", nfs, 2);

    // Asynchronous reset mid-line, sampled between clock edges.
    wait_hv(3, 5);
    #2 rst = 1'b0;
    #1;
    check("async_rst_lat1", v1, R1);
    check("async_rst_lat3", v3, R3);
    check("async_rst_busy", 13'(busy1), 13'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    n = 0;
    n1 = 0;
    n3 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n++;
      if (fs1 && n1 == 0) n1 = n;
      if (fs3 && n3 == 0) n3 = n;
      if (n3 != 0) break;
    end
    check_int("post_rst_fs_lat1", n1, 2);
    check_int("post_rst_fs_lat3", n3, 4);
    repeat (80) @(negedge clk);

    // Full-size default timing on the third instance.
    #2 rst_b = 1'b1;
    @(negedge clk);
    en_b = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n++;
      if (fsd) break;
    end
    check_int("dflt_first_fs", n, 2);
    first_ls = 0;
    ls_cnt = 0;
    hlow = 0;
    vlow = 0;
    first_v = -1;
    fx = -1;
    fy = -1;
    nval = 0;
    lx = -1;
    ly = -1;
    lastc = -1;
    nz = 0;
    for (int c = 0; c < 28944; c++) begin
      if (c > 0) @(negedge clk);
      if (lsd) begin
        ls_cnt++;
        if (c > 0 && first_ls == 0) first_ls = c;
      end
      if (c < 800 && !hsd) hlow++;
      if (!vsd) vlow++;
      if (pvd) begin
        if (first_v < 0) begin
          first_v = c;
          fx = int'(xd);
          fy = int'(yd);
        end
        nval++;
        lx = int'(xd);
        ly = int'(yd);
        lastc = c;
      end else if (xd != 12'd0 || yd != 12'd0) begin
        nz++;
      end
    end
    check_int("dflt_line_period", first_ls, 800);
    check_int("dflt_line_count", ls_cnt, 37);
    check_int("dflt_hsync_width", hlow, 96);
    check_int("dflt_vsync_width", vlow, 1600);
    check_int("dflt_first_valid", first_v, 28144);
    check_int("dflt_first_x", fx, 0);
    check_int("dflt_first_y", fy, 0);
    check_int("dflt_line_pixels", nval, 640);
    check_int("dflt_last_x", lx, 639);
    check_int("dflt_last_y", ly, 0);
    check_int("dflt_last_cycle", lastc, 28783);
    check_int("dflt_zero_outside", nz, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller: generates hsync/vsync, active-area flag and pixel coordinates for any timing set.
- Adds programmable sync polarity, frame/line strobes, and a start/stop state machine that only begins or ends output on frame boundaries.
- Adds a configurable output pipeline delay so timing aligns with downstream pixel-memory read latency.
- Sits between the pixel clock domain and the framebuffer/colour generator.

Parameters:
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- H_POL, 0, active level of hsync (0 = active-low)
- V_POL, 0, active level of vsync
- CW, 12, counter and coordinate width; must satisfy 2^CW > max(H_TOTAL, V_TOTAL)
- LAT, 1, output register stages (range 1..4)

Ports:
- pix_clk  in  1  pixel clock
- pix_rst  in  1  asynchronous active-low reset
- en  in  1  run request, level-sensitive
- pix_x  out  CW  horizontal coordinate inside active area, 0 outside
- pix_y  out  CW  vertical coordinate inside active area, 0 outside
- hsync  out  1  horizontal sync, polarity H_POL
- vsync  out  1  vertical sync, polarity V_POL
- pix_valid  out  1  inside active area
- line_start  out  1  one-cycle pulse at cnt_h==0 while RUN
- frame_start  out  1  one-cycle pulse at cnt_h==0 && cnt_v==0 while RUN
- busy  out  1  state != IDLE

Behaviour:
- Derived constants: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise.
- Counters: cnt_h counts 0..H_TOTAL-1, then wraps to 0 and advances cnt_v. cnt_v counts 0..V_TOTAL-1, then wraps to 0.
- Sync active: cnt_h < H_SYNC (hsync), cnt_v < V_SYNC (vsync).
- Active area: H_SYNC+H_BP <= cnt_h < H_SYNC+H_BP+H_ACTIVE, and the same form vertically. Bounds are exclusive; exactly H_ACTIVE x V_ACTIVE valid pixels per frame.
- pix_x = cnt_h-(H_SYNC+H_BP) and pix_y = cnt_v-(V_SYNC+V_BP) when valid; otherwise 0.
- States:
  - IDLE: counters held at 0. Syncs at inactive level, other outputs 0. en=1 -> RUN on the next edge, with cnt_h=cnt_v=0 in the first RUN cycle.
  - RUN: counters advance every cycle. en=0 -> STOP.
  - STOP: counters keep running until the last pixel of the frame (cnt_h==H_TOTAL-1 && cnt_v==V_TOTAL-1). Then: if en=1, go to RUN and the frame wraps seamlessly; else go to IDLE.
  - en re-asserted mid-STOP: stay in STOP until the frame ends, then RUN with no gap.
- All outputs are computed combinationally from the counters and state, then delayed through LAT register stages. Total latency from counter value to port is LAT cycles, and all outputs stay mutually aligned.
- busy is undelayed.
- Reset (pix_rst=0, async): state IDLE, counters 0, all pipeline stages cleared to the inactive values (hsync=~H_POL, vsync=~V_POL, others 0). Reset mid-frame aborts immediately, with no partial-frame completion.
- Out-of-range LAT or CW is an elaboration error.

Test Plan:
- Defaults, en=1 from reset:
  - first frame_start appears LAT+1 cycles after en is sampled
  - 800 cycles between line_start pulses
  - 420000 cycles between frame_start pulses
- Defaults, one full frame:
  - exactly 307200 pix_valid cycles
  - first valid pixel (0,0) at cnt_h=144, cnt_v=35
  - last valid pixel (639,479) at cnt_h=783, cnt_v=514
  - pix_x/pix_y = 0 whenever pix_valid=0
- Sync widths and polarity:
  - defaults: hsync low for 96 cycles per line, vsync low for 2 lines (1600 cycles)
  - with H_POL=V_POL=1: same widths, inverted levels
- en drop mid-frame at cnt_v=100:
  - frame completes, outputs go idle at the frame end, busy falls
  - en pulsed again during STOP: next frame starts back-to-back with no idle cycle
- LAT=3: every output shifts exactly 2 cycles later than LAT=1, with mutual alignment checked.
- Async reset asserted mid-line: outputs reach inactive values with no clock edge; on release with en=1, a fresh frame_start follows.
